// File: rtl/ej32_pkg.sv
// ej32_pkg: shared fetch-path types for the ej32 core.
// Holds the fetch FSM encoding, the address type and a queue pointer-width helper.
package ej32_pkg;

    localparam int ASZ_DEF = 17;

    typedef logic [ASZ_DEF-1:0] addr_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_DROP
    } fetch_state_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ej32_fetch_q.sv
// ej32_fetch_q: circular byte queue; each byte carries its fetch address.
// Head outputs come straight from the storage registers.
module ej32_fetch_q
    import ej32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 17
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [7:0]                   push_d,
    input  logic [AW-1:0]                push_a,
    input  logic                         pop,
    input  logic                         flush,
    output logic [7:0]                   head_d,
    output logic [AW-1:0]                head_a,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NE = 2 ** PW;

    logic [7:0]    q_d [NE];
    logic [AW-1:0] q_a [NE];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_pop;
    logic          do_push;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt;
    assign head_d  = q_d[rd_ptr];
    assign head_a  = q_a[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < NE; i++) begin
                q_d[i] <= '0;
                q_a[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                q_d[wr_ptr] <= push_d;
                q_a[wr_ptr] <= push_a;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= nxt(rd_ptr);
            if (do_push && !do_pop)
                cnt <= cnt + CW'(1);
            else if (do_pop && !do_push)
                cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/ej32_fetch.sv
// ej32_fetch: byte-wide instruction fetch with redirect and stale-ack drop.
// EJ32_FETCH_PREFETCH_EN selects a QDEPTH-byte prefetch queue; otherwise depth 1.
module ej32_fetch
    import ej32_pkg::*;
#(
    parameter int ASZ    = 17,
    parameter int QDEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           br_psel,
    input  logic [ASZ-1:0] br_p,
    output logic           mem_req,
    output logic [ASZ-1:0] mem_a,
    input  logic           mem_ack,
    input  logic [7:0]     mem_d,
    output logic [7:0]     data,
    output logic [ASZ-1:0] p,
    output logic           d_vld,
    input  logic           adv
);

`ifdef EJ32_FETCH_PREFETCH_EN
    localparam int QD = QDEPTH;
`else
    localparam int QD = (QDEPTH > 0) ? 1 : 1;
`endif
    localparam int CW  = $clog2(QD + 1);
    localparam int CW1 = CW + 1;

    fetch_state_t   state;
    logic [ASZ-1:0] fa;
    logic [ASZ-1:0] fa_inc;
    logic [CW-1:0]  count;
    logic [CW1-1:0] cnt_after;
    logic           full;
    logic           empty;
    logic           pop;
    logic           push;
    logic           room_idle;
    logic           room_ack;

    assign pop       = adv && !empty;
    assign push      = (state == F_REQ) && mem_ack && !br_psel;
    assign fa_inc    = fa + ASZ'(1);
    // Occupancy once this cycle's ack is pushed and any pop is taken.
    assign cnt_after = {1'b0, count} + CW1'(1) - CW1'(pop);
    assign room_idle = !full || pop;
    assign room_ack  = cnt_after < CW1'(QD);
    assign d_vld     = !empty;

    ej32_fetch_q #(
        .DEPTH (QD),
        .AW    (ASZ)
    ) u_q (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .push_d (mem_d),
        .push_a (mem_a),
        .pop    (pop),
        .flush  (br_psel),
        .head_d (data),
        .head_a (p),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= F_IDLE;
            fa      <= '0;
            mem_req <= 1'b0;
            mem_a   <= '0;
        end else begin
            unique case (state)
                F_IDLE: begin
                    if (br_psel) begin
                        fa      <= br_p;
                        mem_a   <= br_p;
                        mem_req <= 1'b1;
                        state   <= F_REQ;
                    end else if (room_idle) begin
                        mem_a   <= fa;
                        mem_req <= 1'b1;
                        state   <= F_REQ;
                    end
                end
                F_REQ: begin
                    if (mem_ack) begin
                        if (br_psel) begin
                            fa    <= br_p;
                            mem_a <= br_p;
                        end else if (room_ack) begin
                            fa    <= fa_inc;
                            mem_a <= fa_inc;
                        end else begin
                            fa      <= fa_inc;
                            mem_req <= 1'b0;
                            state   <= F_IDLE;
                        end
                    end else if (br_psel) begin
                        fa    <= br_p;
                        state <= F_DROP;
                    end
                end
                F_DROP: begin
                    // Old request stays on the bus until its ack retires it.
                    if (mem_ack) begin
                        fa    <= br_psel ? br_p : fa;
                        mem_a <= br_psel ? br_p : fa;
                        state <= F_REQ;
                    end else if (br_psel) begin
                        fa <= br_p;
                    end
                end
                default: begin
                    state   <= F_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ej32_fetch.sv
// tb_ej32_fetch: directed bench with a scoreboard of consumed bytes.
// Memory model returns a fixed function of the address after ws wait cycles.
module tb_ej32_fetch;
    import ej32_pkg::*;

    localparam int ASZ = 17;
`ifdef EJ32_FETCH_PREFETCH_EN
    localparam int EXP_REQS  = 4;
    localparam int EXP_DRAIN = 6;
`else
    localparam int EXP_REQS  = 1;
    localparam int EXP_DRAIN = 11;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       br_psel = 1'b0;
    logic       adv = 1'b0;
    addr_t      br_p = '0;
    logic       mem_req;
    logic       mem_ack;
    logic       d_vld;
    addr_t      mem_a;
    addr_t      p;
    logic [7:0] mem_d;
    logic [7:0] data;
    int         ws = 0;
    int         wcnt = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct packed {
        addr_t      a;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];

    ej32_fetch #(
        .ASZ    (ASZ),
        .QDEPTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .br_psel (br_psel),
        .br_p    (br_p),
        .mem_req (mem_req),
        .mem_a   (mem_a),
        .mem_ack (mem_ack),
        .mem_d   (mem_d),
        .data    (data),
        .p       (p),
        .d_vld   (d_vld),
        .adv     (adv)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mdata(input addr_t a);
        return a[7:0] + a[15:8] + ({7'd0, a[16]} * 8'h55) + 8'h10;
    endfunction

    assign mem_ack = mem_req && (wcnt >= ws);
    assign mem_d   = mdata(mem_a);

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack)
            wcnt <= 0;
        else
            wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_seq(input addr_t start, input int k);
        addr_t a;
        for (int i = 0; i < k; i++) begin
            a = start + addr_t'(i);
            sb.push_back('{a: a, d: mdata(a)});
        end
    endtask

    task automatic drain(input int budget, output int n);
        adv = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            cyc();
            n++;
        end
        adv = 1'b0;
        chk("drain_left", sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && adv && d_vld) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_extra got p=%0h exp none", p);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_p", p, e.a);
                chk("sb_data", data, e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acks;
        int stale;

        repeat (3) cyc();
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_d_vld", d_vld, 0);
        chk("rst_p", p, 0);
        chk("rst_data", data, 0);

        cyc();
        rst = 1'b0;
        cyc();
        @(negedge clk);
        chk("first_req", mem_req, 1);
        chk("first_a", mem_a, 0);
        chk("first_vld", d_vld, 0);
        acks = 0;
        repeat (8) begin
            if (mem_req && mem_ack) acks++;
            cyc();
            @(negedge clk);
        end
        chk("fill_reqs", acks, EXP_REQS);
        chk("fill_req_low", mem_req, 0);
        chk("fill_vld", d_vld, 1);
        chk("fill_p", p, 0);
        chk("fill_data", data, 8'h10);

        cyc();
        expect_seq('0, 6);
        drain(40, n);
        chk("stream_cycles", n, EXP_DRAIN);

        repeat (6) cyc();
        br_psel = 1'b1;
        br_p = 17'h00100;
        cyc();
        br_psel = 1'b0;
        @(negedge clk);
        chk("br_vld_off", d_vld, 0);
        chk("br_mem_a", mem_a, 17'h00100);
        chk("br_mem_req", mem_req, 1);
        cyc();
        @(negedge clk);
        chk("br_vld_on", d_vld, 1);
        chk("br_p", p, 17'h00100);
        chk("br_data", data, mdata(17'h00100));
        cyc();
        expect_seq(17'h00100, 3);
        drain(40, n);

        repeat (6) cyc();
        ws = 3;
        br_psel = 1'b1;
        br_p = 17'h00300;
        cyc();
        br_p = 17'h00200;
        @(negedge clk);
        chk("drop_old_a", mem_a, 17'h00300);
        chk("drop_old_req", mem_req, 1);
        cyc();
        br_psel = 1'b0;
        stale = 0;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (d_vld) stale++;
            if (c == 4) chk("drop_hold_a", mem_a, 17'h00300);
            if (c == 5) chk("drop_new_a", mem_a, 17'h00200);
            cyc();
        end
        @(negedge clk);
        chk("drop_no_stale", stale, 0);
        chk("drop_vld", d_vld, 1);
        chk("drop_p", p, 17'h00200);
        cyc();
        expect_seq(17'h00200, 2);
        drain(80, n);

        ws = 0;
        br_psel = 1'b1;
        br_p = 17'h1FFFF;
        cyc();
        br_psel = 1'b0;
        expect_seq(17'h1FFFF, 3);
        drain(40, n);

        ws = 3;
        br_psel = 1'b1;
        br_p = 17'h00050;
        cyc();
        br_psel = 1'b0;
        rst = 1'b1;
        cyc();
        @(negedge clk);
        chk("mrst_req", mem_req, 0);
        chk("mrst_a", mem_a, 0);
        chk("mrst_vld", d_vld, 0);
        chk("mrst_p", p, 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_idle", mem_req, 0);
        cyc();
        @(negedge clk);
        chk("mrst_req1", mem_req, 1);
        chk("mrst_a1", mem_a, 0);
        cyc();
        expect_seq('0, 2);
        drain(80, n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
